// File: rtl/simple_dma_video_out.sv
// ----------------------------------------------------------------------------
// simple_dma_video_out
//
// Video timing generator and pixel output stage that sits directly after the
// SDRAM DMA read engine. It runs horizontal/vertical counters, strobes one
// pixel read per active pixel into the DMA engine, and re-times the returned
// pixel so that pixel, data-enable and both syncs leave on the same edge.
//
// Handshake: there is no ready. pix_rd_o high in cycle N is a read request
// that the DMA engine must honour; pix_data_i is taken as valid in cycle
// N+1, and the pixel appears on pix_o (with de_o high) in cycle N+2.
//
// Ports
//   clk_i          single clock
//   rst_i          asynchronous, active-high reset
//   en_i           run request (level); a frame in flight always completes
//   pix_rd_o       pixel read strobe to the DMA engine (combinational decode)
//   pix_data_i     pixel from the DMA engine, valid 1 cycle after pix_rd_o
//   frame_start_o  one-cycle pulse on the first pixel read of each frame
//   hsync_o        horizontal sync, active level HSYNC_POL
//   vsync_o        vertical sync, active level VSYNC_POL
//   de_o           data enable
//   pix_o          output pixel, forced to 0 while de_o is low
// ----------------------------------------------------------------------------
module simple_dma_video_out #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   PIX_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic             pix_rd_o,
    input  logic [PIX_W-1:0] pix_data_i,
    output logic             frame_start_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [PIX_W-1:0] pix_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [HCW-1:0]   h_cnt_q, h_cnt_d;
    logic [VCW-1:0]   v_cnt_q, v_cnt_d;

    // Stage 1: registered region decodes
    logic             act_s1_q, act_s1_d;
    logic             hs_s1_q,  hs_s1_d;
    logic             vs_s1_q,  vs_s1_d;

    // Stage 2: output registers
    logic             de_q,    de_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [PIX_W-1:0] pix_q,   pix_d;

    logic             running;
    logic             active_c;
    logic             hs_reg_c;
    logic             vs_reg_c;

    // ------------------------------------------------------------------
    // State machine and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == V_LAST) begin
                        // End of frame: the only point where en_i is honoured.
                        // With en_i high the next frame follows with no gap.
                        v_cnt_d = '0;
                        if (!en_i) begin
                            state_d = IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + VCW'(1);
                    end
                end else begin
                    h_cnt_d = h_cnt_q + HCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Region decodes (gated by RUN so IDLE is inactive everywhere)
    // ------------------------------------------------------------------
    always_comb begin
        running  = (state_q == RUN);
        active_c = running && (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        hs_reg_c = running && (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
        vs_reg_c = running && (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    end

    assign pix_rd_o      = active_c;
    assign frame_start_o = running && (h_cnt_q == '0) && (v_cnt_q == '0);

    // ------------------------------------------------------------------
    // Two-stage output pipeline. Stage 1 lines up with the DMA's one-cycle
    // read latency, so pix_data_i is captured while act_s1_q marks it valid.
    // ------------------------------------------------------------------
    always_comb begin
        act_s1_d = active_c;
        hs_s1_d  = hs_reg_c;
        vs_s1_d  = vs_reg_c;
        de_d     = act_s1_q;
        hsync_d  = hs_s1_q ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = vs_s1_q ? VSYNC_POL : ~VSYNC_POL;
        pix_d    = act_s1_q ? pix_data_i : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            act_s1_q <= 1'b0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            de_q     <= 1'b0;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            act_s1_q <= act_s1_d;
            hs_s1_q  <= hs_s1_d;
            vs_s1_q  <= vs_s1_d;
            de_q     <= de_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            pix_q    <= pix_d;
        end
    end

    assign de_o    = de_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign pix_o   = pix_q;

endmodule

// File: tb/tb_simple_dma_video_out.sv
// ----------------------------------------------------------------------------
// tb_simple_dma_video_out
//
// Small-format bench (16 x 8 total, 8 x 4 active). The reference model tracks
// only "running" and a flat position within the frame (0..127); every timing
// expectation is derived from that position with div/mod arithmetic and then
// delayed two cycles for the registered outputs. A DMA model answers each
// observed read strobe with a random pixel one cycle later and pushes it onto
// the expected queue that pix_o is checked against.
// ----------------------------------------------------------------------------
module tb_simple_dma_video_out;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;   // 16
    localparam int VT = VA + VFP + VS + VBP;   // 8
    localparam int FT = HT * VT;               // 128

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } dec_t;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        pix_rd_o;
    logic [15:0] pix_data_i;
    logic        frame_start_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;
    logic [15:0] pix_o;

    always #5 clk_i = ~clk_i;

    simple_dma_video_out #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_W(16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .pix_rd_o     (pix_rd_o),
        .pix_data_i   (pix_data_i),
        .frame_start_o(frame_start_o),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .de_o         (de_o),
        .pix_o        (pix_o)
    );

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];

    bit          m_run;
    int          m_pos;
    dec_t        d1, d2;
    bit          rd_seen;
    int          dut_strobes;
    int          model_strobes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
        end
    endtask

    // Timing decode straight from the flat frame position.
    function automatic dec_t decode(input bit run, input int pos);
        dec_t d;
        int   h, v;
        h     = pos % HT;
        v     = pos / HT;
        d.act = run && (h < HA) && (v < VA);
        d.hs  = run && (h >= HA + HFP) && (h < HA + HFP + HS);
        d.vs  = run && (v >= VA + VFP) && (v < VA + VFP + VS);
        return d;
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_pos   = 0;
        d1      = '0;
        d2      = '0;
        rd_seen = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd"},  {31'd0, pix_rd_o},      32'd0);
        check({tag, "_fs"},  {31'd0, frame_start_o}, 32'd0);
        check({tag, "_de"},  {31'd0, de_o},          32'd0);
        check({tag, "_pix"}, {16'd0, pix_o},         32'd0);
        check({tag, "_hs"},  {31'd0, hsync_o},       32'd1);
        check({tag, "_vs"},  {31'd0, vsync_o},       32'd1);
    endtask

    // Compare all outputs against the model for the current cycle.
    task automatic compare_cycle();
        dec_t        now;
        logic [15:0] exp_pix;
        now = decode(m_run, m_pos);
        check("pix_rd",      {31'd0, pix_rd_o},      {31'd0, now.act});
        check("frame_start", {31'd0, frame_start_o}, {31'd0, (m_run && m_pos == 0)});
        check("de",          {31'd0, de_o},          {31'd0, d2.act});
        check("hsync",       {31'd0, hsync_o},       {31'd0, ~d2.hs});
        check("vsync",       {31'd0, vsync_o},       {31'd0, ~d2.vs});
        if (d2.act) begin
            if (exp_q.size() == 0) begin
                check("pix_underrun", 32'd1, 32'd0);
            end else begin
                exp_pix = exp_q.pop_front();
                check("pix", {16'd0, pix_o}, {16'd0, exp_pix});
            end
        end else begin
            check("pix_blank", {16'd0, pix_o}, 32'd0);
        end
        if (now.act) model_strobes++;
        if (pix_rd_o === 1'b1) dut_strobes++;
        rd_seen = (pix_rd_o === 1'b1);
    endtask

    // One clock cycle: drive en, advance model at the edge, answer the DMA
    // read, then check at the falling edge.
    task automatic cycle(input logic en);
        logic [15:0] v;
        en_i = en;
        @(posedge clk_i);
        d2 = d1;
        d1 = decode(m_run, m_pos);
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FT - 1) begin
            m_pos = 0;
            if (!en) m_run = 1'b0;
        end else begin
            m_pos++;
        end
        #1;
        v = 16'($urandom);
        pix_data_i = v;
        if (rd_seen) exp_q.push_back(v);
        @(negedge clk_i);
        compare_cycle();
    endtask

    task automatic run_cycles(input logic en, input int n);
        for (int i = 0; i < n; i++) cycle(en);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit hit;
        rst_i         = 1'b1;
        en_i          = 1'b0;
        pix_data_i    = '0;
        dut_strobes   = 0;
        model_strobes = 0;
        model_reset();

        repeat (3) @(negedge clk_i);
        check_reset_values("reset");
        rst_i = 1'b0;

        // Idle for 5 cycles, then back-to-back frames with en held high.
        run_cycles(1'b0, 5);
        run_cycles(1'b1, 2 * FT + 40);

        // Drop en mid-frame: frame completes, then stays idle.
        run_cycles(1'b0, FT + 40);

        // Re-assert, then random en activity.
        run_cycles(1'b1, $urandom_range(1, 300));
        for (int i = 0; i < 6 * FT; i++) begin
            cycle(($urandom_range(0, 15) != 0) ? (($urandom_range(0, 40) == 0) ? ~en_i : en_i) : en_i);
        end

        // Reset asserted in the middle of an active line.
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 4 * FT) begin
            cycle(1'b1);
            n++;
            if (m_run && (m_pos % HT) == 4 && (m_pos / HT) < VA) hit = 1'b1;
        end
        check("mid_line_found", {31'd0, hit}, 32'd1);
        rst_i = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        repeat (2) @(negedge clk_i);
        check_reset_values("rst_held");
        rst_i = 1'b0;

        // After release: idle until en, then random frames.
        run_cycles(1'b0, 20);
        run_cycles(1'b1, FT + $urandom_range(0, 100));
        run_cycles(1'b0, FT + 20);

        check("strobe_total", dut_strobes, model_strobes);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
